// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//
// General-purpose register file for the 32-bit processor datapath: one write
// port with per-byte write mask and two independent read ports. Register 0 can
// be hardwired to zero, a write can be forwarded to a same-cycle read of the
// same address (bypass), and read data can optionally be registered for one
// cycle of latency.
//
// Ports:
//   clock    in   rising-edge clock
//   clear    in   asynchronous active-low reset; clears the array (and the
//                 read registers when REG_OUT=1)
//   we       in   write enable
//   waddr    in   [ADDR_W]   write address
//   wdata    in   [WIDTH]    write data
//   wmask    in   [WIDTH/8]  byte write enables, bit k covers wdata[8k+7:8k]
//   raddr_a  in   [ADDR_W]   read address, port A
//   raddr_b  in   [ADDR_W]   read address, port B
//   rdata_a  out  [WIDTH]    read data, port A
//   rdata_b  out  [WIDTH]    read data, port B
// -----------------------------------------------------------------------------
module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_OUT  = 0
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wmask,
    input  logic [ADDR_W-1:0]    raddr_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [WIDTH-1:0]     rdata_a,
    output logic [WIDTH-1:0]     rdata_b
);

    localparam int NBYTES = WIDTH / 8;

    // Elaboration-time parameter sanity checks.
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
        $error("reg_file_param: WIDTH must be a positive multiple of 8");
    end
    if (NUM_REGS < 2 || NUM_REGS > 256) begin : g_bad_num_regs
        $error("reg_file_param: NUM_REGS must be within 2..256");
    end
    if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_addr_w
        $error("reg_file_param: ADDR_W too narrow for NUM_REGS");
    end

    // Byte-wise merge: masked bytes come from the new word, the rest are kept.
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0]  old_word,
        input logic [WIDTH-1:0]  new_word,
        input logic [NBYTES-1:0] mask
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NBYTES; k++) begin
            if (mask[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // True when the address names an implemented register.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < 32'(NUM_REGS);
    endfunction

    // Addresses that must always read as zero: beyond the array, or the
    // hardwired register 0.
    function automatic logic reads_zero(input logic [ADDR_W-1:0] addr);
        return !in_range(addr) || ((ZERO_REG != 0) && (addr == '0));
    endfunction

    // Resolve one read port: zero rules first, then bypass of a same-cycle
    // valid write, then the stored word.
    function automatic logic [WIDTH-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              wr_hit_ok,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [WIDTH-1:0]  wr_word
    );
        if (reads_zero(addr)) begin
            return '0;
        end else if ((BYPASS != 0) && wr_hit_ok && (addr == wr_addr)) begin
            return wr_word;
        end else begin
            return stored;
        end
    endfunction

    logic [WIDTH-1:0]  regs [NUM_REGS];

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_idx;
    logic [WIDTH-1:0]  wr_merged;
    logic [ADDR_W-1:0] rd_idx_a;
    logic [ADDR_W-1:0] rd_idx_b;
    logic [WIDTH-1:0]  rd_a_p0;
    logic [WIDTH-1:0]  rd_b_p0;

    // ---- Stage p0: write qualification, merge and combinational read ----
    // A write with an empty mask changes nothing, so it is not treated as a
    // write at all; this also keeps it from triggering the bypass path.
    always_comb begin
        wr_valid  = we && (wmask != '0) && !reads_zero(waddr);
        // Out-of-range addresses are steered to entry 0 so the array index is
        // always legal; the result is discarded by wr_valid / reads_zero.
        wr_idx    = in_range(waddr)   ? waddr   : '0;
        rd_idx_a  = in_range(raddr_a) ? raddr_a : '0;
        rd_idx_b  = in_range(raddr_b) ? raddr_b : '0;
        wr_merged = merge_bytes(regs[wr_idx], wdata, wmask);
        rd_a_p0   = read_sel(raddr_a, regs[rd_idx_a], wr_valid, waddr, wr_merged);
        rd_b_p0   = read_sel(raddr_b, regs[rd_idx_b], wr_valid, waddr, wr_merged);
    end

    // Register 0 is never written when ZERO_REG=1 because wr_valid excludes it,
    // so its storage simply stays at the reset value.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[wr_idx] <= wr_merged;
        end
    end

    // ---- Stage p1: optional read output register ----
    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] rd_a_p1;
        logic [WIDTH-1:0] rd_b_p1;

        // Sampling rd_x_p0 at the edge captures either the bypassed merged
        // word or the pre-edge stored word, matching the BYPASS setting.
        always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
                rd_a_p1 <= '0;
                rd_b_p1 <= '0;
            end else begin
                rd_a_p1 <= rd_a_p0;
                rd_b_p1 <= rd_b_p0;
            end
        end

        assign rdata_a = rd_a_p1;
        assign rdata_b = rd_b_p1;
    end else begin : g_comb_out
        assign rdata_a = rd_a_p0;
        assign rdata_b = rd_b_p0;
    end

endmodule
